// File: rtl/seq_multiplier_if.sv
// Handshake and operand/result bundle between the control unit and seq_multiplier.
// The master side issues requests; the slave side is the multiplier.
interface seq_multiplier_if #(
    parameter int SIZE = 32
);
    logic            start;
    logic            is_signed;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] hi;
    logic [SIZE-1:0] lo;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-and-add multiplier producing a 2*SIZE-bit {hi, lo} product
// for mult/multu; one custom_adder iteration per clock, sign fixed up at the end.

module custom_adder #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    input  logic            Cin,
    output logic [SIZE-1:0] Result,
    output logic            Cout
);
    assign {Cout, Result} = {1'b0, A} + {1'b0, B} + {{SIZE{1'b0}}, Cin};
endmodule

module seq_multiplier #(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_multiplier_if.slave   bus
);
    localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] mcand_q, mcand_d;
    logic [SIZE-1:0] mreg_q,  mreg_d;
    logic [SIZE-1:0] acc_q,   acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic            neg_q,   neg_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic [SIZE-1:0] hi_q,    hi_d;
    logic [SIZE-1:0] lo_q,    lo_d;

    logic [SIZE-1:0] add_b;
    logic [SIZE-1:0] add_sum;
    logic            add_cout;
    logic [SIZE-1:0] a_mag;
    logic [SIZE-1:0] b_mag;
    logic [2*SIZE-1:0] prod_raw;
    logic [2*SIZE-1:0] prod_fix;

    // The most negative operand negates to itself, which is its correct unsigned magnitude.
    assign a_mag = (bus.is_signed && bus.a[SIZE-1]) ? (~bus.a + 1'b1) : bus.a;
    assign b_mag = (bus.is_signed && bus.b[SIZE-1]) ? (~bus.b + 1'b1) : bus.b;

    assign add_b    = mreg_q[0] ? mcand_q : '0;
    assign prod_raw = {acc_q, mreg_q};
    assign prod_fix = neg_q ? (~prod_raw + 1'b1) : prod_raw;

    custom_adder #(.SIZE(SIZE)) u_adder (
        .A      (acc_q),
        .B      (add_b),
        .Cin    (1'b0),
        .Result (add_sum),
        .Cout   (add_cout)
    );

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mreg_d  = mreg_q;
        acc_d   = acc_q;
        count_d = count_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d = a_mag;
                    mreg_d  = b_mag;
                    neg_d   = bus.is_signed & (bus.a[SIZE-1] ^ bus.b[SIZE-1]);
                    acc_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Carry enters the accumulator MSB; the sum LSB shifts into the multiplier register.
                acc_d   = {add_cout, add_sum[SIZE-1:1]};
                mreg_d  = {add_sum[0], mreg_q[SIZE-1:1]};
                count_d = count_q + 1'b1;
                if (count_q == CW'(SIZE - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                {hi_d, lo_d} = prod_fix;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mreg_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mreg_q  <= mreg_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed-vector bench for seq_multiplier (SIZE=32): products, latency, busy
// handling, asynchronous reset mid-operation and back-to-back starts.
module tb_seq_multiplier;
    localparam int SIZE    = 32;
    localparam int LAT     = SIZE + 1;
    localparam int MAX_WAIT = 40;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    seq_multiplier_if #(.SIZE(SIZE)) bus ();

    seq_multiplier #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present operands, let the next rising edge accept them, then drop start.
    task automatic launch(input logic [31:0] ai, input logic [31:0] bi, input logic sg);
        bus.a         = ai;
        bus.b         = bi;
        bus.is_signed = sg;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
    endtask

    // Called just after the accepting edge; returns just after the done edge.
    task automatic wait_result(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input logic hold_chk, input logic [31:0] hold_lo);
        int lat;
        int hold_bad;
        lat      = 0;
        hold_bad = 0;
        check({tag, "_busy_after_accept"}, 64'(bus.busy), 64'd1);
        for (int n = 1; n <= MAX_WAIT; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
            if (hold_chk && bus.lo !== hold_lo) hold_bad++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        if (hold_chk) check({tag, "_lo_held"}, 64'(hold_bad), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] ai, input logic [31:0] bi, input logic sg,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        launch(ai, bi, sg);
        wait_result(tag, exp_hi, exp_lo, 1'b0, 32'd0);
    endtask

    initial begin
        int stray_done;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic unsigned product, plus done being a single-cycle pulse.
        run_op("u3x5", 32'd3, 32'd5, 1'b0, 32'h0000_0000, 32'h0000_000F);
        @(posedge clk);
        #1;
        check("u3x5_done_pulse", 64'(bus.done), 64'd0);
        check("u3x5_result_held", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);

        run_op("u_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("u_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b0, 32'h0000_0004, 32'hFFFF_FFF1);
        run_op("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);
        run_op("s_minx1", 32'h8000_0000, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("s_m3xm5", 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 32'h0000_0000, 32'h0000_000F);
        run_op("u_zero", 32'd0, 32'h1234_5678, 1'b0, 32'h0000_0000, 32'h0000_0000);

        // Start pulsed mid-operation with new operands must be ignored.
        launch(32'd7, 32'd9, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        bus.a         = 32'd2;
        bus.b         = 32'd2;
        bus.is_signed = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        stray_done = 0;
        for (int n = 6; n <= MAX_WAIT; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                stray_done = n;
                break;
            end
        end
        check("busy_ign_latency", 64'(stray_done), 64'(LAT));
        check("busy_ign_lo", {bus.hi, bus.lo}, 64'd63);

        // Asynchronous reset mid-CALC abandons the operation.
        launch(32'd11, 32'd13, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(bus.busy), 64'd0);
        check("async_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("async_rst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray_done = 0;
        for (int n = 0; n < MAX_WAIT; n++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) stray_done++;
        end
        check("async_rst_no_done", 64'(stray_done), 64'd0);
        run_op("after_rst_6x7", 32'd6, 32'd7, 1'b0, 32'h0, 32'd42);

        // Back-to-back: second start presented in the done cycle.
        run_op("b2b_first", 32'd2, 32'd3, 1'b0, 32'h0, 32'd6);
        launch(32'd4, 32'd5, 1'b0);
        wait_result("b2b_second", 32'h0, 32'd20, 1'b1, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
